// File: rtl/msp_pkg.sv
// Shared encodings for the operand fetch sequencer and its mode decoder:
// calculator mode codes, address-source selects, instruction format and addressing fields.
package msp_pkg;

  typedef enum logic [2:0] {
    MC_NONE         = 3'd0,
    MC_SRC_INC      = 3'd1,
    MC_SRC_IDX      = 3'd2,
    MC_DST_IDX      = 3'd3,
    MC_DST_IDX_LATE = 3'd4
  } mc_t;

  typedef enum logic [2:0] {
    MAB_PC   = 3'd0,
    MAB_RS   = 3'd1,
    MAB_CALC = 3'd2,
    MAB_RD   = 3'd3,
    MAB_MDB  = 3'd4
  } mab_t;

  localparam logic [1:0] FMT_I   = 2'd0;
  localparam logic [1:0] FMT_II  = 2'd1;
  localparam logic [1:0] FMT_JMP = 2'd2;
  localparam logic [1:0] FMT_RSV = 2'd3;

  localparam logic [1:0] AS_REG  = 2'd0;
  localparam logic [1:0] AS_IDX  = 2'd1;
  localparam logic [1:0] AS_IND  = 2'd2;
  localparam logic [1:0] AS_AUTO = 2'd3;

  localparam logic AD_REG = 1'b0;
  localparam logic AD_IDX = 1'b1;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

endpackage

// File: rtl/operand_mode_dec.sv
// Classifies a decoded instruction's addressing fields into the operand
// accesses the sequencer has to perform.
module operand_mode_dec
  import msp_pkg::*;
(
  input  logic [1:0] fmt,
  input  logic [1:0] as_mode,
  input  logic       ad_mode,
  input  logic [3:0] sreg,
  input  logic [3:0] dreg,
  output logic       need_sext,
  output logic       need_scalc,
  output logic       src_abs,
  output logic       src_imm,
  output logic       src_cg,
  output logic       need_dext,
  output logic       dst_abs,
  output logic       need_write
);

  logic two_op;
  logic one_op;
  logic has_src;

  always_comb begin
    two_op     = (fmt == FMT_I);
    one_op     = (fmt == FMT_II);
    // constant generator: R3 in any mode, R2 in the two indirect modes
    src_cg     = (sreg == REG_CG) || ((sreg == REG_SR) && as_mode[1]);
    has_src    = (two_op || one_op) && !src_cg;
    src_imm    = has_src && (as_mode == AS_AUTO) && (sreg == REG_PC);
    src_abs    = has_src && (as_mode == AS_IDX) && (sreg == REG_SR);
    need_sext  = has_src && ((as_mode == AS_IDX) || src_imm);
    need_scalc = has_src && (as_mode == AS_IDX) && !src_abs;
    need_dext  = two_op && (ad_mode == AD_IDX);
    dst_abs    = need_dext && (dreg == REG_SR);
    need_write = need_dext || (one_op && has_src && (as_mode != AS_REG));
  end

endmodule

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: walks extension fetches, address calculation,
// operand reads, execute handoff and write-back for one decoded instruction.
//
// state  | meaning
// IDLE   | waiting for start
// S_FEXT | source extension word (or immediate) fetch at PC
// S_CALC | source indexed address calculation
// S_READ | source read at CALC_OUT / MDB
// S_IND  | source read at Rs
// S_AUTO | source read at Rs with autoincrement
// D_FEXT | destination extension word fetch at PC
// D_CALC | destination indexed address calculation
// D_READ | destination read at CALC_OUT / MDB
// EXEC   | execute enabled until exec_done
// WRITE  | destination write-back
// DONE   | completion pulse
module operand_fetch_seq
  import msp_pkg::*;
#(
  parameter int unsigned CALC_LAT = 2,
  parameter int unsigned W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] fmt,
  input  logic [1:0] as_mode,
  input  logic       ad_mode,
  input  logic [3:0] sreg,
  input  logic [3:0] dreg,
  input  logic       mem_ready,
  input  logic       exec_done,
  output logic [2:0] mc,
  output logic [2:0] mab_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       pc_inc,
  output logic       src_inc,
  output logic       exec_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam int unsigned addr_w_unused = W;

  typedef enum logic [3:0] {
    ST_IDLE, ST_S_FEXT, ST_S_CALC, ST_S_READ, ST_S_IND, ST_S_AUTO,
    ST_D_FEXT, ST_D_CALC, ST_D_READ, ST_EXEC, ST_WRITE, ST_DONE
  } state_t;

  state_t           state, state_nxt, src_entry, dst_entry;
  logic [1:0]       fmt_q, as_q, fmt_d, as_d;
  logic             ad_q, ad_d, idle;
  logic [3:0]       sreg_q, dreg_q, sreg_d, dreg_d;
  logic [CNT_W-1:0] cnt;
  mab_t             wr_sel;
  logic             src_late;
  logic             need_sext, need_scalc, src_abs, src_imm, src_cg;
  logic             need_dext, dst_abs, need_write;

  // in IDLE the live fields steer the first transition; afterwards the latched copy
  always_comb begin
    idle   = (state == ST_IDLE);
    fmt_d  = idle ? fmt     : fmt_q;
    as_d   = idle ? as_mode : as_q;
    ad_d   = idle ? ad_mode : ad_q;
    sreg_d = idle ? sreg    : sreg_q;
    dreg_d = idle ? dreg    : dreg_q;
  end

  operand_mode_dec u_mode_dec (
    .fmt        (fmt_d),
    .as_mode    (as_d),
    .ad_mode    (ad_d),
    .sreg       (sreg_d),
    .dreg       (dreg_d),
    .need_sext  (need_sext),
    .need_scalc (need_scalc),
    .src_abs    (src_abs),
    .src_imm    (src_imm),
    .src_cg     (src_cg),
    .need_dext  (need_dext),
    .dst_abs    (dst_abs),
    .need_write (need_write)
  );

  always_comb begin
    src_late  = need_sext && !src_imm;
    dst_entry = need_dext ? ST_D_FEXT : ST_EXEC;
    src_entry = dst_entry;
    if (fmt_d == FMT_JMP)                     src_entry = ST_EXEC;
    else if (fmt_d == FMT_RSV)                src_entry = ST_DONE;
    else if (need_sext)                       src_entry = ST_S_FEXT;
    else if (!src_cg && (as_d == AS_IND))     src_entry = ST_S_IND;
    else if (!src_cg && (as_d == AS_AUTO))    src_entry = ST_S_AUTO;

    // write-back reuses whichever address the operand was read from
    if (need_dext)             wr_sel = dst_abs ? MAB_MDB : MAB_CALC;
    else if (as_d == AS_IDX)   wr_sel = src_abs ? MAB_MDB : MAB_CALC;
    else if (src_imm)          wr_sel = MAB_PC;
    else                       wr_sel = MAB_RS;

    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = src_entry;
      ST_S_FEXT: if (mem_ready)
                   state_nxt = src_imm ? dst_entry : (need_scalc ? ST_S_CALC : ST_S_READ);
      ST_S_CALC: if (cnt == '0) state_nxt = ST_S_READ;
      ST_D_CALC: if (cnt == '0) state_nxt = ST_D_READ;
      ST_S_READ, ST_S_IND, ST_S_AUTO:
                 if (mem_ready) state_nxt = dst_entry;
      ST_D_FEXT: if (mem_ready) state_nxt = dst_abs ? ST_D_READ : ST_D_CALC;
      ST_D_READ: if (mem_ready) state_nxt = ST_EXEC;
      ST_EXEC:   if (exec_done) state_nxt = need_write ? ST_WRITE : ST_DONE;
      ST_WRITE:  if (mem_ready) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      fmt_q   <= '0;
      as_q    <= '0;
      ad_q    <= 1'b0;
      sreg_q  <= '0;
      dreg_q  <= '0;
      cnt     <= '0;
      mc      <= MC_NONE;
      mab_sel <= MAB_PC;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      exec_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idle && start) begin
        fmt_q  <= fmt;
        as_q   <= as_mode;
        ad_q   <= ad_mode;
        sreg_q <= sreg;
        dreg_q <= dreg;
      end
      if ((state_nxt != state) && ((state_nxt == ST_S_CALC) || (state_nxt == ST_D_CALC)))
        cnt <= CNT_W'(CALC_LAT - 1);
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);

      mc      <= MC_NONE;
      mab_sel <= MAB_PC;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      exec_en <= 1'b0;
      done    <= 1'b0;
      busy    <= (state_nxt != ST_IDLE);
      case (state_nxt)
        ST_S_FEXT, ST_D_FEXT: mem_rd <= 1'b1;
        ST_S_CALC: mc <= MC_SRC_IDX;
        ST_D_CALC: mc <= src_late ? MC_DST_IDX_LATE : MC_DST_IDX;
        ST_S_READ: begin
          mem_rd  <= 1'b1;
          mab_sel <= src_abs ? MAB_MDB : MAB_CALC;
        end
        ST_S_IND, ST_S_AUTO: begin
          mem_rd  <= 1'b1;
          mab_sel <= MAB_RS;
        end
        ST_D_READ: begin
          mem_rd  <= 1'b1;
          mab_sel <= dst_abs ? MAB_MDB : MAB_CALC;
        end
        ST_EXEC:  exec_en <= 1'b1;
        ST_WRITE: begin
          mem_wr  <= 1'b1;
          mab_sel <= wr_sel;
        end
        ST_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_inc  = mem_ready && mem_rd && ((state == ST_S_FEXT) || (state == ST_D_FEXT));
  assign src_inc = mem_ready && (state == ST_S_AUTO);

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Bench for operand_fetch_seq: directed timing traces plus randomized
// instructions checked against an access-list reference model.
module tb_operand_fetch_seq;

  localparam int CALC_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] fmt;
  logic [1:0] as_mode;
  logic       ad_mode;
  logic [3:0] sreg;
  logic [3:0] dreg;
  logic       mem_ready;
  logic       exec_done;
  logic [2:0] mc;
  logic [2:0] mab_sel;
  logic       mem_rd, mem_wr, pc_inc, src_inc, exec_en, busy, done;

  int checks = 0;
  int errors = 0;

  logic [11:0] trace[$], tr_exp[$];
  logic [3:0]  acc_q[$], exp_acc[$];
  logic [2:0]  mcs_q[$], exp_mc[$];
  int          pc_cnt, si_cnt, ex_cyc, exp_pc, exp_si;
  bit          exp_ex;

  operand_fetch_seq #(.CALC_LAT(CALC_LAT), .W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fmt       (fmt),
    .as_mode   (as_mode),
    .ad_mode   (ad_mode),
    .sreg      (sreg),
    .dreg      (dreg),
    .mem_ready (mem_ready),
    .exec_done (exec_done),
    .mc        (mc),
    .mab_sel   (mab_sel),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .pc_inc    (pc_inc),
    .src_inc   (src_inc),
    .exec_en   (exec_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int m, ms, rd, wr, pc, si, ex, dn);
    pk = {3'(m), 3'(ms), 1'(rd), 1'(wr), 1'(pc), 1'(si), 1'(ex), 1'(dn)};
  endfunction

  function automatic int all_outs();
    all_outs = int'({mc, mab_sel, mem_rd, mem_wr, pc_inc, src_inc, exec_en, busy, done});
  endfunction

  // Expected memory accesses ({wr, mab_sel}), calc modes and pulse counts from the addressing rules.
  task automatic model(input logic [1:0] f, input logic [1:0] a, input logic d,
                       input logic [3:0] s, input logic [3:0] r);
    bit cg;
    logic [3:0] last;
    exp_acc.delete(); exp_mc.delete();
    exp_pc = 0; exp_si = 0;
    exp_ex = (f != 2'd3);
    if (f[1]) return;
    cg = (s == 4'd3) || (s == 4'd2 && a[1]);
    if (!cg) begin
      if (a == 2'd1) begin
        exp_acc.push_back(4'h0); exp_pc++;
        if (s == 4'd2) exp_acc.push_back(4'h4);
        else begin
          repeat (CALC_LAT) exp_mc.push_back(3'd2);
          exp_acc.push_back(4'h2);
        end
      end else if (a == 2'd2) exp_acc.push_back(4'h1);
      else if (a == 2'd3 && s == 4'd0) begin exp_acc.push_back(4'h0); exp_pc++; end
      else if (a == 2'd3) begin exp_acc.push_back(4'h1); exp_si++; end
    end
    if (f == 2'd0 && d) begin
      exp_acc.push_back(4'h0); exp_pc++;
      if (r == 4'd2) exp_acc.push_back(4'h4);
      else begin
        repeat (CALC_LAT) exp_mc.push_back((a == 2'd1 && !cg) ? 3'd4 : 3'd3);
        exp_acc.push_back(4'h2);
      end
    end
    if ((f == 2'd0 && d) || (f == 2'd1 && a != 2'd0 && !cg)) begin
      last = exp_acc[exp_acc.size()-1];
      exp_acc.push_back({1'b1, last[2:0]});
    end
  endtask

  // Issue one instruction and observe it to completion. dly<0 selects random
  // memory/execute latencies; noise adds ignored start and mem_ready pulses.
  task automatic run_instr(input logic [1:0] f, input logic [1:0] a, input logic d,
                           input logic [3:0] s, input logic [3:0] r,
                           input int dly, input bit noise);
    int wait_cnt, ex_cnt, cycles;
    bit in_acc, in_ex, pend, fin;
    logic [4:0] pend_sig;
    trace.delete(); acc_q.delete(); mcs_q.delete();
    pc_cnt = 0; si_cnt = 0; ex_cyc = 0;
    wait_cnt = 0; ex_cnt = 0; cycles = 0;
    in_acc = 0; in_ex = 0; pend = 0; fin = 0; pend_sig = '0;
    model(f, a, d, s, r);
    @(negedge clk);
    start = 1'b1; fmt = f; as_mode = a; ad_mode = d; sreg = s; dreg = r;
    mem_ready = noise && ($urandom_range(0, 1) == 0);
    exec_done = 1'b0;
    while (!fin && cycles < 300) begin
      @(negedge clk);
      cycles++;
      start = noise && busy && ($urandom_range(0, 5) == 0);
      if (start) begin
        fmt = 2'($urandom); as_mode = 2'($urandom); ad_mode = 1'($urandom);
        sreg = 4'($urandom); dreg = 4'($urandom);
      end
      if (mem_rd || mem_wr) begin
        if (!in_acc) begin
          in_acc = 1;
          wait_cnt = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        end
        mem_ready = (wait_cnt == 0);
        if (wait_cnt > 0) wait_cnt--;
      end else mem_ready = noise && ($urandom_range(0, 2) == 0);
      if (exec_en) begin
        if (!in_ex) begin
          in_ex = 1;
          ex_cnt = (dly < 0) ? int'($urandom_range(0, 3)) : 0;
        end
        exec_done = (ex_cnt == 0);
        if (ex_cnt > 0) ex_cnt--;
      end else exec_done = noise && ($urandom_range(0, 3) == 0);
      #1;
      chk("busy_during", int'(busy), 1);
      if (pend) chk("strobe_stable", int'({mem_rd, mem_wr, mab_sel}), int'(pend_sig));
      trace.push_back(pk(mc, (mem_rd || mem_wr) ? int'(mab_sel) : 0,
                         mem_rd, mem_wr, pc_inc, src_inc, exec_en, done));
      pend = 0;
      if ((mem_rd || mem_wr) && mem_ready) begin
        acc_q.push_back({mem_wr, mab_sel});
        in_acc = 0;
      end else if (mem_rd || mem_wr) begin
        pend = 1;
        pend_sig = {mem_rd, mem_wr, mab_sel};
      end
      if (mc != 3'd0) mcs_q.push_back(mc);
      pc_cnt += int'(pc_inc);
      si_cnt += int'(src_inc);
      if (exec_en) ex_cyc++;
      if (exec_en && exec_done) in_ex = 0;
      if (done) fin = 1;
    end
    chk("finished_in_budget", int'(fin), 1);
    start = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_after_done", int'({busy, done}), 0);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_acc_n"}, acc_q.size(), exp_acc.size());
    for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
      chk($sformatf("%s_acc%0d", tag, i), int'(acc_q[i]), int'(exp_acc[i]));
    chk({tag, "_mc_n"}, mcs_q.size(), exp_mc.size());
    for (int i = 0; i < mcs_q.size() && i < exp_mc.size(); i++)
      chk($sformatf("%s_mc%0d", tag, i), int'(mcs_q[i]), int'(exp_mc[i]));
    chk({tag, "_pc_inc"}, pc_cnt, exp_pc);
    chk({tag, "_src_inc"}, si_cnt, exp_si);
    chk({tag, "_exec"}, int'(ex_cyc > 0), int'(exp_ex));
  endtask

  task automatic cmp_trace(input string tag);
    chk({tag, "_len"}, trace.size(), tr_exp.size());
    for (int i = 0; i < trace.size() && i < tr_exp.size(); i++)
      chk($sformatf("%s_cyc%0d", tag, i), int'(trace[i]), int'(tr_exp[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fmt = '0; as_mode = '0; ad_mode = 1'b0;
    sreg = '0; dreg = '0; mem_ready = 1'b0; exec_done = 1'b0;
    #12;
    chk("reset_outputs", all_outs(), 0);
    @(negedge clk); rst = 1'b0;

    // register-register
    run_instr(2'd0, 2'd0, 1'b0, 4'd5, 4'd6, 0, 1'b0);
    tr_exp.delete();
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1));
    cmp_trace("regreg"); cmp_model("regreg");

    // indexed source, memory always ready
    run_instr(2'd0, 2'd1, 1'b0, 4'd5, 4'd6, 0, 1'b0);
    tr_exp.delete();
    tr_exp.push_back(pk(0, 0, 1, 0, 1, 0, 0, 0));
    tr_exp.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 2, 1, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1));
    cmp_trace("indexed"); cmp_model("indexed");

    // immediate with memory three cycles late
    run_instr(2'd0, 2'd3, 1'b0, 4'd0, 4'd6, 3, 1'b0);
    tr_exp.delete();
    repeat (3) tr_exp.push_back(pk(0, 0, 1, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 1, 0, 1, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1));
    cmp_trace("immediate"); cmp_model("immediate");

    // indexed source and indexed destination with write-back
    run_instr(2'd0, 2'd1, 1'b1, 4'd4, 4'd6, 0, 1'b0);
    tr_exp.delete();
    tr_exp.push_back(pk(0, 0, 1, 0, 1, 0, 0, 0));
    repeat (2) tr_exp.push_back(pk(2, 0, 0, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 2, 1, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 1, 0, 1, 0, 0, 0));
    repeat (2) tr_exp.push_back(pk(4, 0, 0, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 2, 1, 0, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
    tr_exp.push_back(pk(0, 2, 0, 1, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1));
    cmp_trace("idx_idx"); cmp_model("idx_idx");

    // single-operand autoincrement
    run_instr(2'd1, 2'd3, 1'b0, 4'd7, 4'd0, 0, 1'b0);
    tr_exp.delete();
    tr_exp.push_back(pk(0, 1, 1, 0, 0, 1, 0, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
    tr_exp.push_back(pk(0, 1, 0, 1, 0, 0, 0, 0));
    tr_exp.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1));
    cmp_trace("autoinc"); cmp_model("autoinc");

    // asynchronous reset in the middle of a destination calculation
    @(negedge clk);
    start = 1'b1; fmt = 2'd0; as_mode = 2'd0; ad_mode = 1'b1; sreg = 4'd4; dreg = 4'd6;
    mem_ready = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("rst_pre_fext", int'({mem_rd, mab_sel}), 'h8);
    @(negedge clk); #1;
    chk("rst_pre_mc", int'(mc), 3);
    #1 rst = 1'b1;
    #1 chk("rst_async_outputs", all_outs(), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_released_idle", all_outs(), 0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("rst_no_retry", all_outs(), 0);

    // randomized instructions with ignored start/mem_ready noise
    for (int k = 0; k < 160; k++) begin
      logic [1:0] rf, ra;
      logic       rd_;
      logic [3:0] rs, rr;
      rf  = ($urandom_range(0, 7) < 6) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      ra  = 2'($urandom);
      rd_ = 1'($urandom);
      rs  = 4'($urandom);
      rr  = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'($urandom);
      run_instr(rf, ra, rd_, rs, rr, -1, 1'b1);
      cmp_model($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
